// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch (IF)
// and data (MEM) pipeline stages. One fixed-latency transaction at a time,
// round-robin on ties, with per-stage stall outputs for the hazard logic.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t            state;
    logic              prio_d;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;

    logic d_req;
    logic grant_d;
    logic grant_if;
    logic issue;
    logic done;

    // Grant decision in IDLE; a simultaneous read+write is serviced as a store.
    always_comb begin
        d_req    = d_mem_read | d_mem_write;
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (!rst && state == IDLE) begin
            grant_d  = d_req & (~if_req | prio_d);
            grant_if = if_req & ~grant_d;
        end
        issue = grant_d | grant_if;
        done  = !rst && state != IDLE && cnt == '0;
    end

    // Memory-side strobes, pass-through on issue, completion pulses and stalls.
    always_comb begin
        mem_en    = issue;
        mem_we    = grant_d & d_mem_write;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if (grant_d) begin
            mem_addr = d_addr;
            if (d_mem_write) begin
                mem_wdata = d_wdata;
            end
        end else if (grant_if) begin
            mem_addr = if_addr;
        end
        if_valid  = done && state == BUSY_IF;
        d_valid   = done && state == BUSY_D;
        if_rdata  = if_valid ? mem_rdata : '0;
        d_rdata   = (d_valid && !lat_we) ? mem_rdata : '0;
        stall_if  = if_req & ~if_valid;
        stall_mem = d_req & ~d_valid;
    end

    // Transaction sequencer: latch on issue, count down latency, return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio_d    <= 1'b1;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        cnt      <= LAT_LOAD;
                        lat_addr <= mem_addr;
                        lat_we   <= grant_d & d_mem_write;
                        if (grant_d && d_mem_write) begin
                            lat_wdata <= d_wdata;
                        end
                        prio_d <= grant_if;
                        state  <= grant_d ? BUSY_D : BUSY_IF;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (lw/sw, driven by the control unit's mem_read/mem_write).
Arbitrates between the two requesters, sequences each fixed-latency memory transaction, and returns data and completion pulses.
Generates per-stage stall signals for the pipeline hazard logic.
Sits between the pipeline registers and the memory macro.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from the mem_en issue cycle to mem_rdata valid; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction, valid only with if_valid
if_valid  out  1  one-cycle fetch completion pulse
d_mem_read  in  1  load request, level
d_mem_write  in  1  store request, level
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid only with d_valid
d_valid  out  1  one-cycle load/store completion pulse
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address, stable for the whole transaction
mem_wdata  out  DATA_W  memory write data, stable for the whole transaction
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
stall_if  out  1  IF stage must hold
stall_mem  out  1  MEM stage (and upstream) must hold

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_D. Reset state is IDLE.
- Reset values: state IDLE; prio_d=1; latency counter 0; mem_en, mem_we, if_valid, d_valid = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- Data request: d_req = d_mem_read | d_mem_write.
  - Both read and write asserted is illegal; treat it as a write.
- Grant in IDLE, cycle T:
  - Only one requester active: grant it.
  - Both active: grant data if prio_d=1, else grant fetch.
  - After a data grant, prio_d becomes 0. After a fetch grant, prio_d becomes 1 (round-robin; data wins the first tie after reset).
- Issue, cycle T:
  - mem_en=1 combinationally.
  - mem_we=1 only for a granted store.
  - Latch address (and wdata for a store) into internal regs.
  - mem_addr/mem_wdata show the latched values from T+1 through the done cycle.
  - In cycle T they pass through from the granted requester.
  - Load the counter with MEM_LAT-1 and move to BUSY_IF or BUSY_D.
- BUSY: the counter decrements each cycle. mem_en=0. Requester input changes are ignored (latched values are used).
- Done cycle T+MEM_LAT (counter==0 in BUSY):
  - Fetch: assert if_valid with if_rdata = mem_rdata (combinational).
  - Load: assert d_valid with d_rdata = mem_rdata.
  - Store: assert d_valid with d_rdata = 0.
  - Return to IDLE at the next edge.
  - No new issue in the done cycle. Throughput is one transaction per MEM_LAT+1 cycles.
- Requests stay high in the done cycle. A request still high in IDLE at T+MEM_LAT+1 is a new transaction, which is the normal pipeline-advance case.
- Stall outputs (combinational):
  - stall_if = if_req & ~if_valid
  - stall_mem = d_req & ~d_valid
  - Both are 1 while the requester waits for a grant or its transaction is in flight.
- Request deasserted before grant: it is dropped with no side effects.
- Request deasserted mid-transaction: the transaction still completes and the valid pulse still fires; the requester ignores it.
- Reset mid-transaction:
  - At the rst edge, state goes to IDLE and the counter clears.
  - No valid pulse is produced for the aborted access.
  - mem_en=0 while rst=1.
  - The first request after rst deasserts is issued normally.
- The counter width is sized for MEM_LAT up to 15. MEM_LAT=1 gives issue at T and done at T+1.

Test Plan:
- Reset: hold rst 3 cycles with both requests high → mem_en=0, if_valid=0, d_valid=0, all data outputs 0.
- Single fetch, MEM_LAT=2: if_req, if_addr=0x10 at cycle 1; memory returns 0x00500093 → mem_en=1, mem_we=0, mem_addr=0x10 at cycle 1; if_valid=1, if_rdata=0x00500093 at cycle 3; stall_if=1 in cycles 1-2 and 0 in cycle 3.
- Tie arbitration: both requests held continuously after reset (d_mem_read, d_addr=0x100; if_addr=0x4) → grant order data, fetch, data, fetch; mem_en at cycles 1, 4, 7, 10; stall_if stays high through data service.
- Store: d_mem_write, d_addr=0x20, d_wdata=0xDEADBEEF → mem_en=1, mem_we=1 at T; mem_addr=0x20, mem_wdata=0xDEADBEEF stable through T+2; d_valid=1, d_rdata=0 at T+2.
- Input change mid-flight: load at 0x40, d_addr switched to 0x80 at T+1 → mem_addr stays 0x40 until done; exactly one d_valid.
- Reset mid-transaction: fetch issued at T, rst=1 at T+1 → no if_valid at T+2; after rst drops, a new fetch to 0x8 issues and completes with correct data MEM_LAT cycles later.
